// File: rtl/fetch_queue_pkg.sv
// Shared types for the instruction fetch queue: datapath width and the stored {pc, instr} entry.
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-side and decode-side valid/ready handshakes of the fetch queue.
// master: the fetch/decode environment; slave: the queue itself.
interface fetch_queue_if;
    import fetch_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_pc;
    logic [XLEN-1:0] out_instr;

    modport master (
        output in_valid, in_pc, in_instr, out_ready,
        input  in_ready, out_valid, out_pc, out_instr
    );

    modport slave (
        input  in_valid, in_pc, in_instr, out_ready,
        output in_ready, out_valid, out_pc, out_instr
    );

endinterface

// File: rtl/fetch_queue_fq_ptr.sv
// Wrap-around queue pointer: advances on inc, returns to 0 on clr (clr wins).
module fq_ptr #(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    // Next pointer: clear, wrap at DEPTH-1, or step by one.
    always_comb begin
        ptr_d = ptr_q;
        if (clr) begin
            ptr_d = '0;
        end else if (inc) begin
            ptr_d = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: in-order buffer of {pc, instr} pairs between instruction memory
// and decode. flush clears the queue on a redirect.
// Optional build macro FETCH_QUEUE_BYPASS_EN: when the queue is empty, the incoming pair is
// presented to decode in the same cycle and consumed without being stored if decode accepts.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    fetch_queue_if.slave               bus,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  head;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          empty;
    logic          full;
    logic          push;
    logic          pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));
    assign head  = mem_q[rd_ptr];

    assign bus.in_ready = ~full;

    // Output presentation; the bypass path only exists with the macro defined.
    always_comb begin
        bus.out_valid = ~empty;
        bus.out_pc    = head.pc;
        bus.out_instr = head.instr;
`ifdef FETCH_QUEUE_BYPASS_EN
        if (empty && !flush) begin
            bus.out_valid = bus.in_valid;
            bus.out_pc    = bus.in_pc;
            bus.out_instr = bus.in_instr;
        end
`endif
    end

    // flush swallows both handshakes of its cycle. A bypassed pair is written and popped in
    // the same cycle, so both pointers advance and count stays 0.
    assign push = bus.in_valid & bus.in_ready & ~flush;
    assign pop  = bus.out_valid & bus.out_ready & ~flush;

    // Occupancy: next = count + push - pop, cleared by flush.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            unique case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Occupancy register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Entry storage; flush leaves contents in place, only pointers/count are cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr] <= '{pc: bus.in_pc, instr: bus.in_instr};
        end
    end

    fq_ptr #(
        .DEPTH (DEPTH)
    ) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .inc   (push),
        .ptr   (wr_ptr)
    );

    fq_ptr #(
        .DEPTH (DEPTH)
    ) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .inc   (pop),
        .ptr   (rd_ptr)
    );

    assign count = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios followed by random traffic. A queue of expected
// entries is fed from accepted pushes; a monitor on the falling edge compares the DUT head,
// occupancy and handshake flags against it.
module tb_fetch_queue;
    import fetch_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH + 1);
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic [CW-1:0] count;

    fetch_queue_if bus ();

    fetch_queue #(
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus.slave),
        .count (count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    fetch_entry_t sb[$];

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference: FIFO of pairs; accepted when fewer than DEPTH held, flush empties it.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n || flush) begin
            sb.delete();
        end else begin
            bit in_acc;
            bit out_acc;
            in_acc  = bus.in_valid && (sb.size() < DEPTH);
            out_acc = bus.out_ready && (sb.size() != 0 || (BYP && bus.in_valid));
            if (in_acc) sb.push_back('{pc: bus.in_pc, instr: bus.in_instr});
            if (out_acc) void'(sb.pop_front());
        end
    end

    // Monitor: flags, occupancy and presented head against the expected queue.
    always @(negedge clk) begin
        if (rst_n) begin
            bit byp_now;
            bit exp_valid;
            byp_now   = BYP && sb.size() == 0 && !flush;
            exp_valid = (sb.size() != 0) || (byp_now && bus.in_valid);
            check("count", count, sb.size());
            check("in_ready", bus.in_ready, sb.size() != DEPTH);
            check("out_valid", bus.out_valid, exp_valid);
            if (sb.size() != 0) begin
                check("head_pc", bus.out_pc, sb[0].pc);
                check("head_instr", bus.out_instr, sb[0].instr);
            end else if (byp_now && bus.in_valid) begin
                check("bypass_pc", bus.out_pc, bus.in_pc);
                check("bypass_instr", bus.out_instr, bus.in_instr);
            end
        end
    end

    // Apply one cycle of stimulus, then return 1 time unit after the edge.
    task automatic drive(input bit v, input logic [31:0] pc, input bit rdy, input bit fl);
        bus.in_valid  = v;
        bus.in_pc     = pc;
        bus.in_instr  = v ? $urandom : 32'h0;
        bus.out_ready = rdy;
        flush         = fl;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_pc     = '0;
        bus.in_instr  = '0;
        bus.out_ready = 1'b0;
        #1;
        check("rst_count", count, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_pc", bus.out_pc, 0);
        check("rst_out_instr", bus.out_instr, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Asynchronous reset with three entries held.
        for (int i = 0; i < 3; i++) drive(1'b1, 32'h10 + 4 * i, 1'b0, 1'b0);
        check("t1_count_before", count, 3);
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t1_count", count, 0);
        check("t1_out_valid", bus.out_valid, 0);
        check("t1_in_ready", bus.in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Order: fill to DEPTH, then drain in consecutive cycles.
        for (int i = 0; i < 4; i++) drive(1'b1, 32'(4 * i), 1'b0, 1'b0);
        check("t2_count_full", count, 4);
        check("t2_in_ready", bus.in_ready, 0);
        for (int i = 0; i < 4; i++) begin
            check("t2_order_pc", bus.out_pc, 32'(4 * i));
            check("t2_order_valid", bus.out_valid, 1);
            drive(1'b0, 32'h0, 1'b1, 1'b0);
        end
        check("t2_count_empty", count, 0);

        // Full + pop: no push that cycle; push the next.
        for (int i = 0; i < 4; i++) drive(1'b1, 32'h20 + 4 * i, 1'b0, 1'b0);
        drive(1'b1, 32'h50, 1'b1, 1'b0);
        check("t3_count_after_pop", count, 3);
        check("t3_in_ready", bus.in_ready, 1);
        drive(1'b1, 32'h50, 1'b0, 1'b0);
        check("t3_count_refill", count, 4);
        for (int i = 0; i < 4; i++) drive(1'b0, 32'h0, 1'b1, 1'b0);
        check("t3_count_drained", count, 0);

        // Steady stream.
        for (int i = 0; i < 20; i++) drive(1'b1, 32'h100 + 4 * i, 1'b1, 1'b0);
        check("t4_count_stream", count, BYP ? 0 : 1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        check("t4_count_drained", count, 0);

        // Flush wins over a same-cycle push and pop.
        for (int i = 0; i < 2; i++) drive(1'b1, 32'h30 + 4 * i, 1'b0, 1'b0);
        check("t5_count_before", count, 2);
        drive(1'b1, 32'h40, 1'b1, 1'b1);
        check("t5_count", count, 0);
        check("t5_out_valid", bus.out_valid, 0);
        for (int i = 0; i < 3; i++) drive(1'b0, 32'h0, 1'b1, 1'b0);
        check("t5_count_idle", count, 0);

`ifdef FETCH_QUEUE_BYPASS_EN
        // Same-cycle presentation from an empty queue.
        bus.in_valid  = 1'b1;
        bus.in_pc     = 32'h200;
        bus.in_instr  = 32'h1234_5678;
        bus.out_ready = 1'b1;
        #1;
        check("t6_out_valid", bus.out_valid, 1);
        check("t6_out_pc", bus.out_pc, 32'h200);
        @(posedge clk);
        #1;
        check("t6_count_consumed", count, 0);
        drive(1'b1, 32'h204, 1'b0, 1'b0);
        check("t6_count_stored", count, 1);
        drive(1'b0, 32'h0, 1'b1, 1'b0);
        check("t6_count_drained", count, 0);
`endif

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            drive(($urandom % 4) != 0, $urandom & 32'hffff_fffc, ($urandom % 3) != 0,
                  ($urandom % 16) == 0);
        end
        for (int i = 0; i < DEPTH + 1; i++) drive(1'b0, 32'h0, 1'b1, 1'b0);
        check("final_count", count, 0);
        check("final_out_valid", bus.out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
